uart_rx_vote_sampler: RTL and testbench
=======================================

Name: uart_rx_vote_sampler

Overview:
Parametrised oversampling bit-sampler for the UART receiver: synchronises RX, takes 1, 3 or 5 samples centred on the bit period and majority-votes them into one bit. It also reports per-bit noise (non-unanimous samples), keeps a saturating noise counter, and flags illegal prescale settings. It sits between the RX edge/bit counter and the RX FSM/deserialiser, and produces one vote per bit period.

Parameters:
PRESCALE_WIDTH, 6, width of Prescale_SAMP and edge_cnt_SAMP (oversampling ratio up to 2^W-1)
SYNC_STAGES, 2, flops in the RX input synchroniser (0 = bypass, max 3)
NOISE_CNT_WIDTH, 8, width of the saturating noise counter

Ports:
CLK_SAMP  in  1  oversampling clock
RST_SAMP  in  1  async active-low reset
Prescale_SAMP  in  PRESCALE_WIDTH  oversampling ratio P (clocks per bit)
samp_mode  in  2  00=1 sample, 01=3, 10=5, 11=reserved (treated as 3)
RX_IN_SAMP  in  1  raw serial input
dat_samp_en_SAMP  in  1  sampling enable from RX FSM
edge_cnt_SAMP  in  PRESCALE_WIDTH  position within bit, 0..P-1, from edge counter
noise_clr  in  1  synchronous clear of noise_cnt
sampled_bit_SAMP  out  1  voted bit
samp_valid  out  1  1-cycle strobe: new vote on sampled_bit_SAMP
noise_err  out  1  last vote non-unanimous; valid with samp_valid
noise_cnt  out  NOISE_CNT_WIDTH  saturating count of noisy bits
cfg_err  out  1  latched config illegal (P<2)

Behaviour:
- Reset (RST_SAMP=0, async): sampled_bit_SAMP=1, samp_valid=0, noise_err=0, noise_cnt=0, cfg_err=0, synchroniser flops=1, sample state cleared, config regs = mode 01 / P=0.
- Synchroniser: rx_s = RX_IN_SAMP delayed SYNC_STAGES clocks. All sampling uses rx_s. Upstream edge counting uses the same-latency signal.
- Config latch: while dat_samp_en_SAMP=0, Prescale_SAMP and samp_mode are registered every cycle. While en=1, config is frozen; changes are ignored until en drops.
- Effective sample count N from latched mode (1/3/5); k=(N-1)/2; centre C=(P>>1)-1.
- Degrade: if C<k, reduce N to the largest of {5,3,1} with C>=k.
- Illegal: P<2 sets cfg_err=1 (updated with config latch). While illegal, no samples are taken and samp_valid stays 0.
- Sample edges: C-k .. C+k, consecutive edge_cnt values.
- Capture: on each clock with en=1 and edge_cnt_SAMP in the window, count ones += rx_s and samples += 1.
- On the clock where edge_cnt_SAMP==C+k (the last sample), include the current rx_s and, on that same edge:
  - sampled_bit_SAMP <= (ones > k)
  - noise_err <= (ones != 0 && ones != N)
  - samp_valid <= 1 for exactly one cycle
  - clear the accumulators for the next bit.
- sampled_bit_SAMP holds between votes. It is not recomputed each cycle.
- N=1: the vote equals rx_s at edge C; noise_err is always 0.
- noise_cnt: increments on samp_valid&noise_err and saturates at all-ones. noise_clr has priority over increment in the same cycle.
- en deassert mid-bit: partial accumulators are discarded and samp_valid=0. sampled_bit_SAMP returns to 1 the next cycle. noise_err clears. noise_cnt is retained.
- Window edges must be hit in order. An edge_cnt jump past C+k without hitting it produces no vote for that bit. Accumulators clear when edge_cnt_SAMP==0.
- Widths: ones/sample counters are 3 bits. C+k is computed at PRESCALE_WIDTH+1 bits, so there is no wrap.

Test Plan:
- P=8, mode=01, RX constant 0 during en, edge_cnt 0..7 -> samples at edges 2,3,4; samp_valid one cycle after the edge-4 clock; sampled_bit=0, noise_err=0.
- P=16, mode=10, RX=1 except a glitch 0 at edge 6 -> samples at edges 5..9; sampled_bit=1, noise_err=1, noise_cnt 0->1.
- P=4, mode=10 -> degrades to N=3, samples at edges 0,1,2. P=1 -> cfg_err=1, no samp_valid over 3 bit periods.
- en dropped at edge 3 of P=8, mode=01 -> no samp_valid, sampled_bit=1 next cycle. Next bit votes correctly with no residue.
- noise_cnt width 2, four noisy bits -> 1,2,3,3 (saturates). noise_clr asserted on the same cycle as a noisy vote -> 0.
- Mode changed 01->00 while en=1 -> still 3 samples until en falls. Async reset mid-bit -> all outputs at reset values immediately.

Source files
------------

// File: rtl/uart_rx_vote_sampler.sv
// rtl/uart_rx_vote_sampler.sv - oversampling majority-vote bit sampler for the UART receiver
module uart_rx_vote_sampler #(
  parameter int PRESCALE_WIDTH  = 6,
  parameter int SYNC_STAGES     = 2,
  parameter int NOISE_CNT_WIDTH = 8
) (
  input  logic                       CLK_SAMP,
  input  logic                       RST_SAMP,
  input  logic [PRESCALE_WIDTH-1:0]  Prescale_SAMP,
  input  logic [1:0]                 samp_mode,
  input  logic                       RX_IN_SAMP,
  input  logic                       dat_samp_en_SAMP,
  input  logic [PRESCALE_WIDTH-1:0]  edge_cnt_SAMP,
  input  logic                       noise_clr,
  output logic                       sampled_bit_SAMP,
  output logic                       samp_valid,
  output logic                       noise_err,
  output logic [NOISE_CNT_WIDTH-1:0] noise_cnt,
  output logic                       cfg_err
);

  localparam int CW = PRESCALE_WIDTH + 1;

  logic rx_s;

  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign rx_s = RX_IN_SAMP;
    end else begin : g_sync
      logic [SYNC_STAGES-1:0] sync_q;
      always_ff @(posedge CLK_SAMP or negedge RST_SAMP) begin
        if (!RST_SAMP) begin
          sync_q <= '1;
        end else begin
          sync_q[0] <= RX_IN_SAMP;
          for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_q[i] <= sync_q[i-1];
          end
        end
      end
      assign rx_s = sync_q[SYNC_STAGES-1];
    end
  endgenerate

  logic [PRESCALE_WIDTH-1:0] cfg_p;
  logic [1:0]                cfg_mode;

  // Config only follows the inputs between frames so a bit never sees a half-changed window.
  always_ff @(posedge CLK_SAMP or negedge RST_SAMP) begin
    if (!RST_SAMP) begin
      cfg_p    <= '0;
      cfg_mode <= 2'b01;
      cfg_err  <= 1'b0;
    end else if (!dat_samp_en_SAMP) begin
      cfg_p    <= Prescale_SAMP;
      cfg_mode <= samp_mode;
      cfg_err  <= (Prescale_SAMP < PRESCALE_WIDTH'(2));
    end
  end

  logic          illegal;
  logic [CW-1:0] centre;
  logic [CW-1:0] win_lo;
  logic [CW-1:0] edge_w;
  logic [2:0]    n_req;
  logic [2:0]    n_eff;
  logic [1:0]    k;
  logic [2:0]    ones;
  logic [2:0]    samps;
  logic [2:0]    base_ones;
  logic [2:0]    base_samps;
  logic [2:0]    ones_next;
  logic          hit;
  logic          last;

  assign illegal = (cfg_p < PRESCALE_WIDTH'(2));
  assign centre  = CW'(cfg_p >> 1) - CW'(1);
  assign edge_w  = CW'(edge_cnt_SAMP);

  always_comb begin
    n_req = 3'd3;
    n_eff = 3'd1;
    case (cfg_mode)
      2'b00:   n_req = 3'd1;
      2'b10:   n_req = 3'd5;
      default: n_req = 3'd3;
    endcase
    // Shrink the window until it fits below the centre sample.
    if (centre >= CW'(2))      n_eff = n_req;
    else if (centre == CW'(1)) n_eff = (n_req == 3'd5) ? 3'd3 : n_req;
    else                       n_eff = 3'd1;
  end

  assign k      = n_eff[2:1];
  assign win_lo = centre - CW'(k);

  // Edge 0 starts a fresh bit; a sample counts only if it is the next expected window edge.
  always_comb begin
    base_ones  = (edge_cnt_SAMP == '0) ? 3'd0 : ones;
    base_samps = (edge_cnt_SAMP == '0) ? 3'd0 : samps;
    ones_next  = base_ones + {2'b00, rx_s};
    hit        = dat_samp_en_SAMP && !illegal && (base_samps < n_eff) &&
                 (edge_w == win_lo + CW'(base_samps));
    last       = hit && (base_samps == n_eff - 3'd1);
  end

  always_ff @(posedge CLK_SAMP or negedge RST_SAMP) begin
    if (!RST_SAMP) begin
      ones             <= 3'd0;
      samps            <= 3'd0;
      sampled_bit_SAMP <= 1'b1;
      samp_valid       <= 1'b0;
      noise_err        <= 1'b0;
    end else if (!dat_samp_en_SAMP) begin
      ones             <= 3'd0;
      samps            <= 3'd0;
      sampled_bit_SAMP <= 1'b1;
      samp_valid       <= 1'b0;
      noise_err        <= 1'b0;
    end else begin
      samp_valid <= 1'b0;
      if (last) begin
        sampled_bit_SAMP <= (ones_next > {1'b0, k});
        noise_err        <= (ones_next != 3'd0) && (ones_next != n_eff);
        samp_valid       <= 1'b1;
        ones             <= 3'd0;
        samps            <= 3'd0;
      end else if (hit) begin
        ones  <= ones_next;
        samps <= base_samps + 3'd1;
      end else begin
        ones  <= base_ones;
        samps <= base_samps;
      end
    end
  end

  always_ff @(posedge CLK_SAMP or negedge RST_SAMP) begin
    if (!RST_SAMP) begin
      noise_cnt <= '0;
    end else if (noise_clr) begin
      noise_cnt <= '0;
    end else if (samp_valid && noise_err && (noise_cnt != '1)) begin
      noise_cnt <= noise_cnt + NOISE_CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_uart_rx_vote_sampler.sv
// tb/tb_uart_rx_vote_sampler.sv - directed self-checking bench for uart_rx_vote_sampler
module tb_uart_rx_vote_sampler;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] prescale;
  logic [1:0] mode;
  logic       rx;
  logic       en;
  logic [5:0] edge_cnt;
  logic       clr;
  logic       sampled_bit;
  logic       valid;
  logic       nerr;
  logic [1:0] ncnt;
  logic       cerr;

  int compared = 0;
  int mismatched = 0;

  uart_rx_vote_sampler #(
    .PRESCALE_WIDTH(6),
    .SYNC_STAGES(2),
    .NOISE_CNT_WIDTH(2)
  ) dut (
    .CLK_SAMP(clk),
    .RST_SAMP(rst_n),
    .Prescale_SAMP(prescale),
    .samp_mode(mode),
    .RX_IN_SAMP(rx),
    .dat_samp_en_SAMP(en),
    .edge_cnt_SAMP(edge_cnt),
    .noise_clr(clr),
    .sampled_bit_SAMP(sampled_bit),
    .samp_valid(valid),
    .noise_err(nerr),
    .noise_cnt(ncnt),
    .cfg_err(cerr)
  );

  always #5 clk = ~clk;

  // RX is driven two clocks ahead so rx_s lines up with edge_cnt through the synchroniser.
  task automatic setup(input int p, input logic [1:0] m, input logic [31:0] pat);
    en = 1'b0;
    prescale = 6'(p);
    mode = m;
    edge_cnt = 6'd0;
    rx = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    rx = pat[0];
    @(posedge clk); #1;
    rx = pat[1];
    @(posedge clk); #1;
  endtask

  task automatic run_bit(input int p, input logic [31:0] pat, input int drop_at, input int clr_at,
                         output int nv, output int vedge, output logic vb, output logic ve);
    nv = 0;
    vedge = -1;
    vb = 1'b0;
    ve = 1'b0;
    for (int e = 0; e < p; e++) begin
      en = (drop_at < 0) || (e < drop_at);
      clr = (e == clr_at);
      edge_cnt = 6'(e);
      rx = pat[(e + 2) % p];
      @(posedge clk); #1;
      if (valid === 1'b1) begin
        nv++;
        vedge = e;
        vb = sampled_bit;
        ve = nerr;
      end
    end
    clr = 1'b0;
  endtask

  task automatic check_vote(input string name, input int nv, input int vedge, input logic vb, input logic ve,
                            input int x_edge, input logic x_vb, input logic x_ve);
    compared++;
    if (nv !== 1 || vedge !== x_edge || vb !== x_vb || ve !== x_ve) begin
      mismatched++;
      $display("FAIL %s: got valids=%0d edge=%0d bit=%b noise=%b, want valids=1 edge=%0d bit=%b noise=%b",
               name, nv, vedge, vb, ve, x_edge, x_vb, x_ve);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    en = 1'b0; prescale = 6'd8; mode = 2'b01; rx = 1'b1; edge_cnt = 6'd0; clr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    compared++;
    if ({sampled_bit, valid, nerr, ncnt, cerr} !== 6'b100000) begin
      mismatched++;
      $display("FAIL reset: got bit=%b valid=%b noise=%b cnt=%0d cfg=%b, want 1 0 0 0 0",
               sampled_bit, valid, nerr, ncnt, cerr);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    int nv, ve_edge; logic vb, ve;
    setup(8, 2'b01, 32'h0);
    run_bit(8, 32'h0, -1, -1, nv, ve_edge, vb, ve);
    check_vote("basic_p8_n3", nv, ve_edge, vb, ve, 4, 1'b0, 1'b0);
  endtask

  task automatic test_noise();
    int nv, ve_edge; logic vb, ve;
    setup(16, 2'b10, 32'hFFFF_FFBF);
    run_bit(16, 32'hFFFF_FFBF, -1, -1, nv, ve_edge, vb, ve);
    check_vote("glitch_p16_n5", nv, ve_edge, vb, ve, 9, 1'b1, 1'b1);
    compared++;
    if (ncnt !== 2'd1) begin
      mismatched++;
      $display("FAIL noise_cnt_first: got %0d want 1", ncnt);
    end
  endtask

  task automatic test_degrade();
    int nv, ve_edge, total; logic vb, ve;
    setup(4, 2'b10, 32'hE);
    run_bit(4, 32'hE, -1, -1, nv, ve_edge, vb, ve);
    check_vote("degrade_p4", nv, ve_edge, vb, ve, 2, 1'b1, 1'b1);
    compared++;
    if (ncnt !== 2'd2) begin
      mismatched++;
      $display("FAIL noise_cnt_degrade: got %0d want 2", ncnt);
    end
    setup(1, 2'b01, 32'h0);
    compared++;
    if (cerr !== 1'b1) begin
      mismatched++;
      $display("FAIL cfg_err_set: got %b want 1", cerr);
    end
    total = 0;
    for (int b = 0; b < 3; b++) begin
      run_bit(8, 32'h0, -1, -1, nv, ve_edge, vb, ve);
      total += nv;
    end
    compared++;
    if (total !== 0) begin
      mismatched++;
      $display("FAIL illegal_no_valid: got %0d strobes want 0", total);
    end
    setup(8, 2'b01, 32'h0);
    compared++;
    if (cerr !== 1'b0) begin
      mismatched++;
      $display("FAIL cfg_err_clear: got %b want 0", cerr);
    end
  endtask

  task automatic test_en_drop();
    int nv, ve_edge; logic vb, ve;
    run_bit(8, 32'h0, -1, -1, nv, ve_edge, vb, ve);
    check_vote("pre_drop", nv, ve_edge, vb, ve, 4, 1'b0, 1'b0);
    run_bit(8, 32'h0, 3, -1, nv, ve_edge, vb, ve);
    compared++;
    if (nv !== 0 || sampled_bit !== 1'b1 || nerr !== 1'b0) begin
      mismatched++;
      $display("FAIL en_drop: got strobes=%0d bit=%b noise=%b want 0 1 0", nv, sampled_bit, nerr);
    end
    setup(8, 2'b01, 32'hFFFF_FFFF);
    run_bit(8, 32'hFFFF_FFFF, -1, -1, nv, ve_edge, vb, ve);
    check_vote("after_drop", nv, ve_edge, vb, ve, 4, 1'b1, 1'b0);
  endtask

  task automatic test_saturation();
    int nv, ve_edge; logic vb, ve;
    logic [1:0] want;
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    compared++;
    if (ncnt !== 2'd0) begin
      mismatched++;
      $display("FAIL noise_clr_idle: got %0d want 0", ncnt);
    end
    setup(8, 2'b01, 32'hFFFF_FFF7);
    for (int b = 0; b < 4; b++) begin
      want = (b < 3) ? 2'(b + 1) : 2'd3;
      run_bit(8, 32'hFFFF_FFF7, -1, -1, nv, ve_edge, vb, ve);
      compared++;
      if (ncnt !== want || nv !== 1 || ve !== 1'b1) begin
        mismatched++;
        $display("FAIL noise_sat_%0d: got cnt=%0d strobes=%0d noise=%b want cnt=%0d 1 1", b, ncnt, nv, ve, want);
      end
    end
    run_bit(8, 32'hFFFF_FFF7, -1, 5, nv, ve_edge, vb, ve);
    compared++;
    if (ncnt !== 2'd0 || ve !== 1'b1) begin
      mismatched++;
      $display("FAIL noise_clr_priority: got cnt=%0d noise=%b want 0 1", ncnt, ve);
    end
  endtask

  task automatic test_mode_freeze();
    int nv, ve_edge; logic vb, ve;
    setup(8, 2'b01, 32'hFFFF_FFF7);
    mode = 2'b00;
    run_bit(8, 32'hFFFF_FFF7, -1, -1, nv, ve_edge, vb, ve);
    check_vote("mode_frozen", nv, ve_edge, vb, ve, 4, 1'b1, 1'b1);
    setup(8, 2'b00, 32'hFFFF_FFF7);
    run_bit(8, 32'hFFFF_FFF7, -1, -1, nv, ve_edge, vb, ve);
    check_vote("mode_single", nv, ve_edge, vb, ve, 3, 1'b0, 1'b0);
  endtask

  task automatic test_async_reset();
    setup(8, 2'b01, 32'h0);
    for (int e = 0; e < 5; e++) begin
      en = 1'b1;
      edge_cnt = 6'(e);
      rx = 1'b0;
      @(posedge clk); #1;
    end
    compared++;
    if (valid !== 1'b1 || sampled_bit !== 1'b0 || ncnt !== 2'd1) begin
      mismatched++;
      $display("FAIL pre_reset: got valid=%b bit=%b cnt=%0d want 1 0 1", valid, sampled_bit, ncnt);
    end
    #2 rst_n = 1'b0;
    #1;
    compared++;
    if ({sampled_bit, valid, nerr, ncnt, cerr} !== 6'b100000) begin
      mismatched++;
      $display("FAIL async_reset: got bit=%b valid=%b noise=%b cnt=%0d cfg=%b, want 1 0 0 0 0",
               sampled_bit, valid, nerr, ncnt, cerr);
    end
    en = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_noise();
    test_degrade();
    test_en_drop();
    test_saturation();
    test_mode_freeze();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
